// File: rtl/elevador_pkg.sv
// Shared types and widths for the elevator controller.
package elevador_pkg;

    localparam int unsigned ANDAR_W   = 4;
    localparam int unsigned N_ANDARES = 16;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBINDO  = 2'd1,
        DESCENDO = 2'd2,
        PORTA    = 2'd3
    } estado_t;

endpackage

// File: rtl/det_direcao.sv
// Combinational detection of pending requests above and below a given floor.
module det_direcao
    import elevador_pkg::*;
(
    input  logic [N_ANDARES-1:0] i_pedidos,
    input  logic [ANDAR_W-1:0]   i_andar,
    output logic                 o_acima,
    output logic                 o_abaixo
);

    always_comb begin
        o_acima  = 1'b0;
        o_abaixo = 1'b0;
        for (int i = 0; i < int'(N_ANDARES); i++) begin
            if (i > int'(i_andar)) o_acima  = o_acima  | i_pedidos[i];
            if (i < int'(i_andar)) o_abaixo = o_abaixo | i_pedidos[i];
        end
    end

endmodule

// File: rtl/controle_elevador.sv
// SCAN elevator controller: latches floor calls, moves the car one floor per
// T_ANDAR cycles and holds the door open for T_PORTA cycles.
module controle_elevador
    import elevador_pkg::*;
#(
    parameter int unsigned T_ANDAR = 8,
    parameter int unsigned T_PORTA = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_ANDARES-1:0] botao,
    output logic [ANDAR_W-1:0]   andar,
    output logic [N_ANDARES-1:0] pedidos,
    output logic                 motor_sobe,
    output logic                 motor_desce,
    output logic                 porta_aberta,
    output logic                 direcao
);

    localparam int unsigned T_MAX   = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
    localparam int unsigned TIMER_W = $clog2(T_MAX);

    estado_t                r_estado, w_prox_estado;
    logic [ANDAR_W-1:0]     r_andar, w_prox_andar;
    logic [TIMER_W-1:0]     r_timer, w_prox_timer;
    logic                   r_direcao, w_prox_direcao;
    logic [N_ANDARES-1:0]   r_pedidos;
    logic [N_ANDARES-1:0]   w_limpa, w_mascara, w_um_andar;
    logic                   r_motor_sobe, r_motor_desce, r_porta_aberta;
    logic [ANDAR_W-1:0]     w_andar_mais, w_andar_menos;
    logic                   w_acima, w_abaixo, w_acima_mais, w_abaixo_menos;
    logic                   w_abaixo_mais, w_acima_menos, w_unused_det;

    assign w_andar_mais  = r_andar + ANDAR_W'(1);
    assign w_andar_menos = r_andar - ANDAR_W'(1);
    assign w_um_andar    = N_ANDARES'(1) << r_andar;
    // The served floor's own button is ignored while its door is open.
    assign w_mascara     = (r_estado == PORTA) ? w_um_andar : '0;
    assign w_unused_det  = w_abaixo_mais | w_acima_menos;

    det_direcao u_det_atual (
        .i_pedidos (r_pedidos),
        .i_andar   (r_andar),
        .o_acima   (w_acima),
        .o_abaixo  (w_abaixo)
    );

    det_direcao u_det_mais (
        .i_pedidos (r_pedidos),
        .i_andar   (w_andar_mais),
        .o_acima   (w_acima_mais),
        .o_abaixo  (w_abaixo_mais)
    );

    det_direcao u_det_menos (
        .i_pedidos (r_pedidos),
        .i_andar   (w_andar_menos),
        .o_acima   (w_acima_menos),
        .o_abaixo  (w_abaixo_menos)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado       <= PARADO;
            r_andar        <= '0;
            r_timer        <= '0;
            r_direcao      <= 1'b1;
            r_pedidos      <= '0;
            r_motor_sobe   <= 1'b0;
            r_motor_desce  <= 1'b0;
            r_porta_aberta <= 1'b0;
        end else begin
            r_estado       <= w_prox_estado;
            r_andar        <= w_prox_andar;
            r_timer        <= w_prox_timer;
            r_direcao      <= w_prox_direcao;
            r_pedidos      <= (r_pedidos | (botao & ~w_mascara)) & ~w_limpa;
            r_motor_sobe   <= (w_prox_estado == SUBINDO);
            r_motor_desce  <= (w_prox_estado == DESCENDO);
            r_porta_aberta <= (w_prox_estado == PORTA);
        end
    end

    always_comb begin
        w_prox_estado  = r_estado;
        w_prox_andar   = r_andar;
        w_prox_timer   = r_timer;
        w_prox_direcao = r_direcao;
        w_limpa        = '0;
        case (r_estado)
            PARADO: begin
                if (r_pedidos[r_andar]) begin
                    w_prox_estado = PORTA;
                    w_prox_timer  = TIMER_W'(T_PORTA - 1);
                    w_limpa       = w_um_andar;
                end else if (r_direcao && w_acima) begin
                    w_prox_estado = SUBINDO;
                    w_prox_timer  = TIMER_W'(T_ANDAR - 1);
                end else if (!r_direcao && w_abaixo) begin
                    w_prox_estado = DESCENDO;
                    w_prox_timer  = TIMER_W'(T_ANDAR - 1);
                end else if (r_direcao && w_abaixo) begin
                    w_prox_estado  = DESCENDO;
                    w_prox_timer   = TIMER_W'(T_ANDAR - 1);
                    w_prox_direcao = 1'b0;
                end else if (!r_direcao && w_acima) begin
                    w_prox_estado  = SUBINDO;
                    w_prox_timer   = TIMER_W'(T_ANDAR - 1);
                    w_prox_direcao = 1'b1;
                end
            end
            SUBINDO: begin
                if (r_timer == '0) begin
                    w_prox_andar = w_andar_mais;
                    if (r_pedidos[w_andar_mais]) begin
                        w_prox_estado = PORTA;
                        w_prox_timer  = TIMER_W'(T_PORTA - 1);
                        w_limpa       = N_ANDARES'(1) << w_andar_mais;
                    end else if (w_acima_mais) begin
                        w_prox_timer  = TIMER_W'(T_ANDAR - 1);
                    end else begin
                        w_prox_estado = PARADO;
                    end
                end else begin
                    w_prox_timer = r_timer - TIMER_W'(1);
                end
            end
            DESCENDO: begin
                if (r_timer == '0) begin
                    w_prox_andar = w_andar_menos;
                    if (r_pedidos[w_andar_menos]) begin
                        w_prox_estado = PORTA;
                        w_prox_timer  = TIMER_W'(T_PORTA - 1);
                        w_limpa       = N_ANDARES'(1) << w_andar_menos;
                    end else if (w_abaixo_menos) begin
                        w_prox_timer  = TIMER_W'(T_ANDAR - 1);
                    end else begin
                        w_prox_estado = PARADO;
                    end
                end else begin
                    w_prox_timer = r_timer - TIMER_W'(1);
                end
            end
            PORTA: begin
                // Holding the call button of the open floor keeps the door open.
                if (botao[r_andar]) begin
                    w_prox_timer = TIMER_W'(T_PORTA - 1);
                end else if (r_timer == '0) begin
                    w_prox_estado = PARADO;
                end else begin
                    w_prox_timer = r_timer - TIMER_W'(1);
                end
            end
            default: w_prox_estado = PARADO;
        endcase
    end

    assign andar        = r_andar;
    assign pedidos      = r_pedidos;
    assign motor_sobe   = r_motor_sobe;
    assign motor_desce  = r_motor_desce;
    assign porta_aberta = r_porta_aberta;
    assign direcao      = r_direcao;

endmodule

// File: tb/tb_controle_elevador.sv
// Randomized and directed bench for controle_elevador against an elapsed-time
// behavioural model of the SCAN policy.
module tb_controle_elevador;

    localparam int unsigned T_ANDAR = 8;
    localparam int unsigned T_PORTA = 16;

    logic        clk;
    logic        rst_n;
    logic [15:0] botao;
    logic [3:0]  andar;
    logic [15:0] pedidos;
    logic        motor_sobe;
    logic        motor_desce;
    logic        porta_aberta;
    logic        direcao;

    int n_cmp = 0;
    int n_err = 0;

    // Model: car position, motion sign (+1/-1/0), door flag, cycles elapsed in activity.
    int          m_floor;
    int          m_motion;
    int          m_elapsed;
    bit          m_door;
    bit          m_dir;
    logic [15:0] m_ped;

    controle_elevador #(.T_ANDAR(T_ANDAR), .T_PORTA(T_PORTA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .botao        (botao),
        .andar        (andar),
        .pedidos      (pedidos),
        .motor_sobe   (motor_sobe),
        .motor_desce  (motor_desce),
        .porta_aberta (porta_aberta),
        .direcao      (direcao)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_side(input logic [15:0] p, input int f, input int s);
        for (int i = 0; i < 16; i++)
            if (p[i] && (i - f) * s > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_motion = 0; m_elapsed = 0; m_door = 0; m_dir = 1; m_ped = '0;
    endtask

    task automatic model_step(input logic [15:0] b);
        logic [15:0] nova;
        logic [15:0] limpa;
        bit up, dn;
        limpa = '0;
        nova  = m_ped | (m_door ? (b & ~(16'h1 << m_floor)) : b);
        if (m_door) begin
            if (b[m_floor]) m_elapsed = 0;
            else if (m_elapsed + 1 == int'(T_PORTA)) m_door = 0;
            else m_elapsed++;
        end else if (m_motion != 0) begin
            if (m_elapsed + 1 == int'(T_ANDAR)) begin
                m_floor += m_motion;
                m_elapsed = 0;
                if (m_ped[m_floor]) begin
                    m_motion = 0; m_door = 1; limpa = 16'h1 << m_floor;
                end else if (!any_side(m_ped, m_floor, m_motion)) begin
                    m_motion = 0;
                end
            end else begin
                m_elapsed++;
            end
        end else begin
            m_elapsed = 0;
            up = any_side(m_ped, m_floor, 1);
            dn = any_side(m_ped, m_floor, -1);
            if (m_ped[m_floor]) begin
                m_door = 1; limpa = 16'h1 << m_floor;
            end else if (m_dir && up) m_motion = 1;
            else if (!m_dir && dn) m_motion = -1;
            else if (m_dir && dn) begin m_motion = -1; m_dir = 0; end
            else if (!m_dir && up) begin m_motion = 1; m_dir = 1; end
        end
        m_ped = nova & ~limpa;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] f;
        f = 32'(m_floor);
        check({tag, ".andar"},   32'(andar),        {28'd0, f[3:0]});
        check({tag, ".pedidos"}, 32'(pedidos),      32'(m_ped));
        check({tag, ".sobe"},    32'(motor_sobe),   32'(m_motion == 1));
        check({tag, ".desce"},   32'(motor_desce),  32'(m_motion == -1));
        check({tag, ".porta"},   32'(porta_aberta), 32'(m_door));
        check({tag, ".direcao"}, 32'(direcao),      32'(m_dir));
    endtask

    task automatic cycle(input logic [15:0] b);
        @(negedge clk);
        botao = b;
        @(posedge clk);
        model_step(b);
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        botao = '0;
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_porta(input logic v, input string tag);
        for (int k = 0; k < 300 && porta_aberta !== v; k++) cycle('0);
        check(tag, 32'(porta_aberta), 32'(v));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        botao = '0;
        do_reset();
        #1;
        check_all("reset");

        // Idle after reset
        repeat (20) cycle('0);
        check("idle.andar", 32'(andar), 32'd0);
        check("idle.direcao", 32'(direcao), 32'd1);

        // Single call to floor 3
        cycle(16'h0008);
        cycle('0);
        check("f3.sobe_e1", 32'(motor_sobe), 32'd1);
        repeat (24) cycle('0);
        check("f3.andar", 32'(andar), 32'd3);
        check("f3.porta", 32'(porta_aberta), 32'd1);
        check("f3.ped_clear", 32'(pedidos[3]), 32'd0);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            cycle('0);
            if (porta_aberta) n++;
            else break;
        end
        check("f3.porta_ciclos", 32'(n), 32'd16);

        // Door hold at floor 4
        cycle(16'h0010);
        wait_porta(1'b1, "hold.abre");
        check("hold.andar", 32'(andar), 32'd4);
        repeat (30) cycle(16'h0010);
        check("hold.ped4", 32'(pedidos[4]), 32'd0);
        check("hold.porta", 32'(porta_aberta), 32'd1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            cycle('0);
            n++;
            if (!porta_aberta) break;
        end
        check("hold.fecha", 32'(n), 32'd16);

        // From 5 going up with calls at 2 and 9
        do_reset();
        cycle(16'h0020);
        wait_porta(1'b1, "scan.f5");
        wait_porta(1'b0, "scan.f5f");
        cycle(16'h0204);
        wait_porta(1'b1, "scan.a9");
        check("scan.andar9", 32'(andar), 32'd9);
        wait_porta(1'b0, "scan.f9");
        wait_porta(1'b1, "scan.a2");
        check("scan.andar2", 32'(andar), 32'd2);
        check("scan.dir", 32'(direcao), 32'd0);

        // Intermediate stop at 6 on the way to 10
        do_reset();
        cycle(16'h0400);
        for (int k = 0; k < 100 && andar !== 4'd2; k++) cycle('0);
        check("mid.em2", 32'(andar), 32'd2);
        cycle(16'h0040);
        wait_porta(1'b1, "mid.a6");
        check("mid.andar6", 32'(andar), 32'd6);
        wait_porta(1'b0, "mid.f6");
        wait_porta(1'b1, "mid.a10");
        check("mid.andar10", 32'(andar), 32'd10);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            logic [15:0] b;
            b = '0;
            if ($urandom_range(0, 9) == 0) b = 16'h1 << $urandom_range(0, 15);
            if ($urandom_range(0, 39) == 0) b = b | (16'h1 << $urandom_range(0, 15));
            if (m_door && $urandom_range(0, 7) == 0) b = b | (16'h1 << m_floor);
            cycle(b);
        end

        // Asynchronous reset while descending between 7 and 6
        do_reset();
        cycle(16'h0080);
        wait_porta(1'b1, "rst.a7");
        wait_porta(1'b0, "rst.f7");
        cycle(16'h0004);
        for (int k = 0; k < 10 && motor_desce !== 1'b1; k++) cycle('0);
        repeat (3) cycle('0);
        check("rst.desce", 32'(motor_desce), 32'd1);
        check("rst.andar7", 32'(andar), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cycle('0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
